ctrl_seq: RTL

Fetch/decode/execute sequencer for the 8-bit machine; sits directly upstream and downstream of the arithmetic unit. Fetches instructions from a 16-word synchronous memory and drives the AU's enable, opcode and operands. Latches the AU result and greater flag back into its accumulator and flag register. It also resolves jumps and drives an output port.

---
 rtl/ctrl_pkg.sv | 33 +++
 rtl/ctrl_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the 8-bit machine sequencer: widths, opcodes, FSM states.
package ctrl_pkg;

  localparam int DW = 8;
  localparam int AW = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_STA  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUTA = 4'hD;
  localparam logic [3:0] OP_JGT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    IRWAIT,
    DECODE,
    EXEC,
    HALT
  } state_t;

  // Opcodes that need an EXEC cycle through the arithmetic unit.
  function automatic logic is_exec_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_OUT) || (op == OP_STA) ||
           (op == OP_OUTA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: drives memory and the arithmetic unit,
// latches AU results into acc/gf_q/out_port and resolves jumps.
//
// state  | meaning
// IDLE   | parked between instructions, waiting for run
// FETCH  | mem_addr = pc
// IRWAIT | capture instruction word, pc += 1
// DECODE | mem_addr = operand address, resolve NOP/JMP/JGT/HLT
// EXEC   | AU enabled, result written to acc/out_port/memory
// HALT   | terminal until reset
module ctrl_seq
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          au_en,
  output logic [3:0]    ac,
  output logic [DW-1:0] au_a,
  output logic [DW-1:0] au_b,
  input  logic [DW-1:0] au_t,
  input  logic          au_gf,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  output logic          halted
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] acc_q;
  logic          gf_q;
  logic [DW-1:0] out_q;
  logic [3:0]    op;
  logic [AW-1:0] tgt;

  assign op       = ir_q[7:4];
  assign tgt      = ir_q[3:0];
  assign au_b     = acc_q;
  assign out_port = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    au_en     = 1'b0;
    ac        = 4'h0;
    au_a      = '0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = FETCH;
      FETCH: begin
        mem_addr = pc_q;
        state_d  = IRWAIT;
      end
      IRWAIT: state_d = DECODE;
      DECODE: begin
        mem_addr = tgt;
        if (op == OP_HLT)       state_d = HALT;
        else if (is_exec_op(op)) state_d = EXEC;
        else                     state_d = run ? FETCH : IDLE;
      end
      EXEC: begin
        mem_addr = tgt;
        au_en    = 1'b1;
        ac       = op;
        au_a     = ((op == OP_STA) || (op == OP_OUTA)) ? acc_q : mem_rdata;
        if (op == OP_STA) begin
          mem_we    = 1'b1;
          mem_wdata = au_t;
        end
        out_valid = (op == OP_OUT) || (op == OP_OUTA);
        state_d   = run ? FETCH : IDLE;
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // A taken jump in DECODE overrides the increment done in IRWAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      gf_q  <= 1'b0;
      out_q <= '0;
    end else begin
      case (state_q)
        IRWAIT: begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + 4'd1;
        end
        DECODE: begin
          if ((op == OP_JMP) || ((op == OP_JGT) && gf_q)) pc_q <= tgt;
        end
        EXEC: begin
          if ((op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB)) acc_q <= au_t;
          if (op == OP_SUB) gf_q <= au_gf;
          if ((op == OP_OUT) || (op == OP_OUTA)) out_q <= au_t;
        end
        default: ;
      endcase
    end
  end

endmodule
